// File: rtl/riscv_mem_pkg.sv
// Types and widths shared by the unified memory arbiter and its helper units.
package riscv_mem_pkg;

    localparam int LAT_W    = 4;
    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
    typedef enum logic [1:0] {NONE, OWN_IF, OWN_D}     owner_t;

    typedef logic [LAT_W-1:0]    lat_cnt_t;
    typedef logic [STREAK_W-1:0] streak_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that flags the final cycle of a fixed-latency memory access.
module mem_lat_counter
    import riscv_mem_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_load,
    input  logic     i_dec,
    input  lat_cnt_t i_load_val,
    output logic     o_last
);

    lat_cnt_t r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && r_cnt != '0) begin
            r_cnt <= r_cnt - lat_cnt_t'(1);
        end
    end

    assign o_last = (r_cnt == lat_cnt_t'(1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and load/store.
// Loads/stores win ties, bounded by a streak limit so a waiting fetch cannot starve.
module unified_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1,
    parameter int MAX_DSTREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_flush,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  stall_if,
    output logic                  stall_mem,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam lat_cnt_t LAT_LOAD   = lat_cnt_t'(MEM_LATENCY);
    localparam streak_t  STREAK_MAX = streak_t'(MAX_DSTREAK);

    arb_state_t            r_state;
    owner_t                r_owner;
    streak_t               r_streak;
    logic                  r_flushed;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_if_ack;
    logic                  r_d_ack;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_rdata_buf;
    logic [DATA_WIDTH-1:0] r_d_rdata;

    logic w_d_win;
    logic w_lat_last;
    logic w_if_commit;

    assign w_d_win = d_req && ((r_streak < STREAK_MAX) || !if_req);
    // A redirect landing in the response cycle itself must still cancel the fetch.
    assign w_if_commit = r_if_ack && !if_flush;

    mem_lat_counter u_lat (
        .clk        (clk),
        .rst        (rst),
        .i_load     (r_state == ISSUE),
        .i_dec      (r_state == WAIT),
        .i_load_val (LAT_LOAD),
        .o_last     (w_lat_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= NONE;
            r_streak    <= '0;
            r_flushed   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_if_rdata  <= '0;
            r_rdata_buf <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_mem_en <= 1'b0;
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            if (if_flush && r_owner == OWN_IF && r_state != IDLE)
                r_flushed <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_d_win) begin
                        r_owner     <= OWN_D;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_streak    <= if_req ? r_streak + streak_t'(1) : '0;
                        r_state     <= ISSUE;
                    end else if (if_req) begin
                        r_owner    <= OWN_IF;
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= if_addr;
                        r_streak   <= '0;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    if (w_lat_last) begin
                        if (r_owner == OWN_D) begin
                            r_d_ack <= 1'b1;
                            if (!r_mem_we)
                                r_d_rdata <= mem_rdata;
                        end else if (!r_flushed && !if_flush) begin
                            r_if_ack    <= 1'b1;
                            r_rdata_buf <= mem_rdata;
                        end
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (w_if_commit)
                        r_if_rdata <= r_rdata_buf;
                    r_owner   <= NONE;
                    r_flushed <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign if_ack    = w_if_commit;
    assign if_rdata  = w_if_commit ? r_rdata_buf : r_if_rdata;
    assign d_ack     = r_d_ack;
    assign d_rdata   = r_d_rdata;
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = d_req & ~d_ack;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the instruction-fetch stage (IF port) and the load/store stage (D port) of the RV32 pipeline.
- Serialises accesses and grants the D port priority, with a starvation guard for fetch.
- Returns one-cycle acks to the requester and drives per-port stall signals to the pipeline registers.
- Supports discarding an in-flight fetch on a PC redirect (taken branch/jump).

Parameters:
- ADDR_WIDTH, 32, byte address width of both ports and memory.
- DATA_WIDTH, 32, data word width.
- MEM_LATENCY, 1, cycles from the mem_en cycle to the cycle in which mem_rdata is valid. Legal range is 1..15.
- MAX_DSTREAK, 4, maximum consecutive D grants allowed while if_req waits. Legal range is 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, level; held until if_ack or if_flush.
- if_addr  in  ADDR_WIDTH  fetch address; stable while if_req is high.
- if_flush  in  1  PC redirect; the outstanding fetch is discarded.
- if_ack  out  1  one-cycle fetch completion.
- if_rdata  out  DATA_WIDTH  instruction; valid in the if_ack cycle, held afterwards.
- d_req  in  1  data request, level; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_ack  out  1  one-cycle data completion.
- d_rdata  out  DATA_WIDTH  load data; valid in the d_ack cycle, unchanged by stores.
- stall_if  out  1  if_req & ~if_ack (combinational).
- stall_mem  out  1  d_req & ~d_ack (combinational).
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable; valid with mem_en.
- mem_addr  out  ADDR_WIDTH  memory address, registered.
- mem_wdata  out  DATA_WIDTH  memory write data, registered.
- mem_rdata  in  DATA_WIDTH  memory read data; valid MEM_LATENCY cycles after mem_en.

Behaviour:
- Reset (async, rst=1): state=IDLE.
  - All outputs are 0: acks, rdata regs, mem_en/we/addr/wdata.
  - owner=NONE, streak=0, lat_cnt=0, flushed=0.
  - stall_* follow their equations.
- FSM states: IDLE, ISSUE, WAIT, RESP. All mem_* and ack outputs are registered.
- IDLE: at the clock edge, pick a winner.
  - D wins if d_req is high and (streak<MAX_DSTREAK or if_req is low).
  - Otherwise IF wins if if_req is high.
  - Latch the winner's address/we/wdata into mem_* and go to ISSUE.
  - A fetch is never issued with we=1.
- ISSUE: mem_en=1 for exactly one cycle; load lat_cnt=MEM_LATENCY; go to WAIT.
- WAIT: decrement lat_cnt each cycle. When lat_cnt==1, capture mem_rdata into the owner's rdata reg (only if owner=D and a load, or owner=IF) and go to RESP.
- RESP: assert the owner's ack for exactly one cycle, then go to IDLE.
  - During RESP the owner's req is ignored.
  - The next arbitration happens in IDLE.
- Latency: a request seen in IDLE cycle c is acked in cycle c+MEM_LATENCY+2. Sustained single-port throughput is one access per MEM_LATENCY+3 cycles.
- Streak counter:
  - On a D grant with if_req high: streak++, saturating at MAX_DSTREAK.
  - On an IF grant, or a D grant with if_req low: streak=0.
- Flush:
  - if_flush high in any of ISSUE/WAIT/RESP with owner=IF sets flushed.
  - A flushed transaction still completes its memory cycle, but in RESP if_ack stays 0 and if_rdata is not updated.
  - if_flush in IDLE, or with owner=D, has no effect.
  - if_flush in the RESP cycle itself suppresses that cycle's ack.
- Simultaneous requests in IDLE: D wins unless the streak limit has been hit; never both.
- Requests may change only after their ack; a mid-transaction change of addr/wdata has no effect, since the values are latched.
- Reset asserted mid-transaction aborts it immediately (mem_en=0, no ack); the requester re-requests.

Decomposition:
- Package riscv_mem_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - owner_t enum {NONE, OWN_IF, OWN_D}.
  - Widths of lat_cnt and streak (4 bits).
- One sub-module, mem_lat_counter (load/decrement/last flag), reusable by future multi-cycle units.
- Arbitration and the FSM stay in the top module.

Test Plan:
1. Reset: assert rst mid-WAIT with MEM_LATENCY=1 -> mem_en, if_ack, d_ack go 0 immediately; all outputs 0 after release, state IDLE.
2. Lone fetch: if_req=1, if_addr=0x00000010, memory word 0x00500093, MEM_LATENCY=1, req in cycle 0 -> mem_en=1 with mem_addr=0x10 in cycle 1; if_ack=1 with if_rdata=0x00500093 in cycle 3; stall_if=1 in cycles 0..2.
3. Collision: if_req and d_req (load 0x100 -> 0xDEADBEEF) both rise in cycle 0 -> D is served first (d_ack in cycle 3, d_rdata=0xDEADBEEF); fetch is issued in cycle 5 and acked in cycle 7.
4. Store: d_we=1, d_addr=0x200, d_wdata=0xABBA0102 -> mem_en=mem_we=1 with those values for one cycle; d_ack in cycle 3; d_rdata keeps its previous value.
5. Starvation: d_req held continuously with MAX_DSTREAK=4 and if_req high -> grant order D,D,D,D,IF,D...; streak returns to 0 after the IF grant.
6. Flush: fetch to 0x40 issued, if_flush pulsed in WAIT -> mem_en still pulses once; no if_ack; if_rdata unchanged; arbiter returns to IDLE in cycle 4.
